hit_report_arbiter: RTL and testbench

Round-robin arbiter that shares one Avalon-MM write master between the sniffer's four hit-count sources: port, IP, MAC and URL. Each winning value is written to a fixed word slot in host-visible memory behind the PCIe bridge. It sits between `ethernetsniffer` (`port_hits`, `ip_hits`, `mac_hits`, `url_hits`) and the Qsys system interconnect.

---
 rtl/sniffer_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/hit_report_arbiter.sv | 119 +++++++++++
 tb/tb_hit_report_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sniffer_pkg.sv
// Shared constants and state encoding for the sniffer hit-report path.
package sniffer_pkg;

    localparam int ADDRESSWIDTH = 28;
    localparam int DATAWIDTH    = 32;

    localparam int REQ_PORT = 0;
    localparam int REQ_IP   = 1;
    localparam int REQ_MAC  = 2;
    localparam int REQ_URL  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        TSTAMP = 2'd2
    } hit_report_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority one-hot pick; the search starts one past the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int PW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               transfer
);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic          found;
    int unsigned   scan_idx;

    always_comb begin
        grant     = '0;
        grant_idx = ptr_reg;
        found     = 1'b0;
        scan_idx  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            scan_idx = (int'(ptr_reg) + off) % NUM_REQ;
            if (!found && req[PW'(scan_idx)]) begin
                found     = 1'b1;
                grant_idx = PW'(scan_idx);
            end
        end
        if (enable && found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign transfer = |(req & grant);
    assign ptr_next = transfer ? grant_idx : ptr_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_reg <= PW'(NUM_REQ - 1);
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/hit_report_arbiter.sv
// Shares one Avalon-MM write master between the sniffer hit counters.
// Optional HIT_REPORT_TIMESTAMP_EN adds a cycle-count write after each report.
module hit_report_arbiter #(
    parameter int ADDRESSWIDTH                 = sniffer_pkg::ADDRESSWIDTH,
    parameter int DATAWIDTH                    = sniffer_pkg::DATAWIDTH,
    parameter int NUM_REQ                      = 4,
    parameter logic [ADDRESSWIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATAWIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [ADDRESSWIDTH-1:0]      avm_address,
    output logic                         avm_write,
    output logic [DATAWIDTH-1:0]         avm_writedata,
    input  logic                         avm_waitrequest,
    output logic                         busy
);
    import sniffer_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    hit_report_state_t       state_reg, state_next;
    logic [ADDRESSWIDTH-1:0] addr_reg, addr_next;
    logic [DATAWIDTH-1:0]    data_reg, data_next;
    logic [DATAWIDTH-1:0]    req_data_arr [NUM_REQ];
    logic [PW-1:0]           grant_idx;
    logic                    transfer;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign req_data_arr[gi] = req_data[gi*DATAWIDTH +: DATAWIDTH];
        end
    endgenerate

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk       (clk),
        .n_rst     (n_rst),
        .req       (req),
        .enable    (state_reg == IDLE),
        .grant     (grant),
        .grant_idx (grant_idx),
        .transfer  (transfer)
    );

`ifdef HIT_REPORT_TIMESTAMP_EN
    localparam logic [ADDRESSWIDTH-1:0] TS_OFFSET = ADDRESSWIDTH'(4 * NUM_REQ);

    logic [31:0] cnt_reg;
    logic [31:0] ts_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_reg <= '0;
            ts_reg  <= '0;
        end else begin
            cnt_reg <= cnt_reg + 32'd1;
            if (transfer) begin
                ts_reg <= cnt_reg;
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        case (state_reg)
            IDLE: begin
                if (transfer) begin
                    addr_next  = BASE_ADDR + (ADDRESSWIDTH'(grant_idx) << 2);
                    data_next  = req_data_arr[grant_idx];
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (!avm_waitrequest) begin
`ifdef HIT_REPORT_TIMESTAMP_EN
                    // Timestamp slots sit directly after the NUM_REQ data slots.
                    addr_next  = addr_reg + TS_OFFSET;
                    data_next  = DATAWIDTH'(ts_reg);
                    state_next = TSTAMP;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef HIT_REPORT_TIMESTAMP_EN
            TSTAMP: begin
                if (!avm_waitrequest) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

    // Strobe derives from the state register so reset clears it immediately.
    assign avm_write     = (state_reg != IDLE);
    assign busy          = (state_reg != IDLE);
    assign avm_address   = addr_reg;
    assign avm_writedata = data_reg;

endmodule

// File: tb/tb_hit_report_arbiter.sv
// Self-checking bench for hit_report_arbiter: vector table, corner sequences, random vs model.
module tb_hit_report_arbiter;

`ifdef HIT_REPORT_TIMESTAMP_EN
    localparam bit TS = 1'b1;
`else
    localparam bit TS = 1'b0;
`endif
    localparam int PER = TS ? 3 : 2;
    localparam logic [27:0] BASE = 28'h0000400;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   grant;
    logic [27:0]  avm_address;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

    hit_report_arbiter #(.BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .req             (req),
        .req_data        (req_data),
        .grant           (grant),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] d2;
        logic        wr;
        logic [3:0]  g;
        logic        w;
        logic [27:0] a;
        logic [31:0] d;
        logic        b;
    } vec_t;

    vec_t tbl [4];
    int   nrows;

    // Reference model state
    int          m_state;
    int          m_ptr;
    logic [27:0] m_addr;
    logic [31:0] m_data;
    logic [31:0] m_ts;
    logic [31:0] m_cnt;
    int          xi;
    int          last_xfer;
    logic [3:0]  exp_g;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        req = '0;
        req_data = '0;
        avm_waitrequest = 1'b0;
        edge_step();
        edge_step();
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        req = '0;
        req_data = '0;
        avm_waitrequest = 1'b0;

        // Reset values
        #3;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_write", 64'(avm_write), 64'h0);
        chk("rst_addr", 64'(avm_address), 64'h0);
        chk("rst_data", 64'(avm_writedata), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);

        // Single request to slot 2
        tbl[0] = '{4'b0100, 32'h000000A5, 1'b0, 4'b0100, 1'b0, 28'h0, 32'h0, 1'b0};
        tbl[1] = '{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, BASE + 28'd8, 32'hA5, 1'b1};
        if (TS) begin
            tbl[2] = '{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, BASE + 28'd24, 32'd0, 1'b1};
            tbl[3] = '{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 28'h0, 32'h0, 1'b0};
            nrows = 4;
        end else begin
            tbl[2] = '{4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 28'h0, 32'h0, 1'b0};
            nrows = 3;
        end
        do_reset();
        for (int r = 0; r < nrows; r++) begin
            req = tbl[r].req;
            req_data[64 +: 32] = tbl[r].d2;
            avm_waitrequest = tbl[r].wr;
            #3;
            chk("tbl_grant", 64'(grant), 64'(tbl[r].g));
            chk("tbl_write", 64'(avm_write), 64'(tbl[r].w));
            chk("tbl_busy", 64'(busy), 64'(tbl[r].b));
            if (tbl[r].w || r == 0) begin
                chk("tbl_addr", 64'(avm_address), 64'(tbl[r].a));
                chk("tbl_data", 64'(avm_writedata), 64'(tbl[r].d));
            end
            edge_step();
        end

        // Fairness with all requests held
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h100 + 32'(i);
        for (int c = 0; c <= 4 * PER; c++) begin
            #3;
            exp_g = (c % PER == 0) ? 4'(1 << ((c / PER) % 4)) : 4'b0000;
            chk("fair_grant", 64'(grant), 64'(exp_g));
            if (c % PER == 1) begin
                chk("fair_addr", 64'(avm_address), 64'(BASE + 28'(4 * ((c / PER) % 4))));
                chk("fair_data", 64'(avm_writedata), 64'(32'h100 + 32'((c / PER) % 4)));
            end
            edge_step();
        end

        // Stall of 5 cycles on requester 1, with late req[3] and req[0] pending
        do_reset();
        req = 4'b0010;
        req_data[32 +: 32] = 32'hBEEF0001;
        #3;
        chk("stall_grant0", 64'(grant), 64'h2);
        edge_step();
        req = 4'b1001;
        req_data[0 +: 32]  = 32'h11;
        req_data[96 +: 32] = 32'h33;
        for (int s = 0; s < 6; s++) begin
            avm_waitrequest = (s < 5);
            #3;
            chk("stall_write", 64'(avm_write), 64'h1);
            chk("stall_nogrant", 64'(grant), 64'h0);
            chk("stall_addr", 64'(avm_address), 64'(BASE + 28'd4));
            chk("stall_data", 64'(avm_writedata), 64'hBEEF0001);
            edge_step();
        end
        avm_waitrequest = 1'b0;
        if (TS) begin
            #3;
            chk("stall_ts_addr", 64'(avm_address), 64'(BASE + 28'd20));
            chk("stall_ts_data", 64'(avm_writedata), 64'h0);
            edge_step();
        end
        #3;
        chk("late_grant", 64'(grant), 64'h8);
        edge_step();

        // Reset mid-write
        do_reset();
        req = 4'b0100;
        req_data[64 +: 32] = 32'h77;
        edge_step();
        req = 4'b0000;
        avm_waitrequest = 1'b1;
        #3;
        chk("mid_write_on", 64'(avm_write), 64'h1);
        edge_step();
        #2;
        n_rst = 1'b0;
        #1;
        chk("mid_write_drop", 64'(avm_write), 64'h0);
        chk("mid_busy_drop", 64'(busy), 64'h0);
        edge_step();
        n_rst = 1'b1;
        avm_waitrequest = 1'b0;
        req = 4'b1111;
        #3;
        chk("mid_first_grant", 64'(grant), 64'h1);
        edge_step();

`ifdef HIT_REPORT_TIMESTAMP_EN
        // Timestamp latched at counter value 100
        do_reset();
        repeat (100) @(posedge clk);
        #1;
        req = 4'b0001;
        req_data[0 +: 32] = 32'h5A5A;
        #3;
        chk("ts_grant", 64'(grant), 64'h1);
        edge_step();
        req = 4'b0000;
        #3;
        chk("ts_data_addr", 64'(avm_address), 64'(BASE));
        chk("ts_data_val", 64'(avm_writedata), 64'h5A5A);
        edge_step();
        #3;
        chk("ts_addr", 64'(avm_address), 64'(BASE + 28'd16));
        chk("ts_val", 64'(avm_writedata), 64'd100);
        edge_step();
        #3;
        chk("ts_idle", 64'(busy), 64'h0);
        edge_step();
`endif

        // Randomised traffic against the reference model
        do_reset();
        m_state = 0;
        m_ptr = 3;
        m_addr = '0;
        m_data = '0;
        m_ts = '0;
        m_cnt = '0;
        last_xfer = -1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (i == last_xfer) begin
                    if ($urandom_range(1, 0) == 1) begin
                        req[i] = 1'b0;
                    end else begin
                        req[i] = 1'b1;
                        req_data[i*32 +: 32] = $urandom;
                    end
                end else if (!req[i] && $urandom_range(9, 0) < 3) begin
                    req[i] = 1'b1;
                    req_data[i*32 +: 32] = $urandom;
                end
            end
            avm_waitrequest = ($urandom_range(9, 0) < 3);
            #3;
            xi = -1;
            if (m_state == 0) begin
                for (int off = 1; off <= 4; off++) begin
                    if (xi < 0 && req[(m_ptr + off) % 4]) xi = (m_ptr + off) % 4;
                end
            end
            exp_g = (xi >= 0) ? 4'(1 << xi) : 4'b0000;
            chk("rnd_grant", 64'(grant), 64'(exp_g));
            chk("rnd_write", 64'(avm_write), 64'(m_state != 0));
            chk("rnd_busy", 64'(busy), 64'(m_state != 0));
            if (m_state != 0) begin
                chk("rnd_addr", 64'(avm_address), 64'(m_addr));
                chk("rnd_data", 64'(avm_writedata), 64'(m_data));
            end
            last_xfer = -1;
            case (m_state)
                0: if (xi >= 0) begin
                    m_addr = BASE + 28'(4 * xi);
                    m_data = req_data[xi*32 +: 32];
                    m_ts = m_cnt;
                    m_ptr = xi;
                    m_state = 1;
                    last_xfer = xi;
                end
                1: if (!avm_waitrequest) begin
                    if (TS) begin
                        m_state = 2;
                        m_addr = m_addr + 28'd16;
                        m_data = m_ts;
                    end else begin
                        m_state = 0;
                    end
                end
                default: if (!avm_waitrequest) m_state = 0;
            endcase
            m_cnt = m_cnt + 32'd1;
            edge_step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
